serial_sub: RTL and testbench

Parametrised digit-serial subtractor: computes a − b − borrowIn on WIDTH-bit operands, DIGIT bits per clock, under a start/busy/done handshake. It is the multi-cycle, width-generic successor to the 4-bit combinational parallel_sub. Datapaths use it where a WIDTH-bit ripple-borrow chain would not close timing in one cycle. It adds signed-overflow and zero flags.

---
 rtl/serial_sub.sv | 106 ++++++++++
 tb/tb_serial_sub.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// Digit-serial subtractor: a - b - borrowIn over WIDTH bits, DIGIT bits per clock,
// with start/busy/done handshake and borrow, signed-overflow and zero flags.
module serial_sub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrowIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrowOut,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] DMASK = {WIDTH{1'b1}} >> (WIDTH - DIGIT);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg, b_reg, res_reg;
  logic             borrow_reg;
  logic [CW-1:0]    cnt_reg;

  int               base;
  logic [DIGIT-1:0] a_dig, b_dig;
  logic [DIGIT:0]   dsub;
  logic [WIDTH-1:0] res_next;
  logic             borrow_next;
  logic             last_digit;
  logic             ovf_next;

  // One DIGIT-wide borrow chain; the digit is picked out by shifting, not by a wide mux tree
  always_comb begin
    base        = int'(cnt_reg) * DIGIT;
    a_dig       = DIGIT'(a_reg >> base);
    b_dig       = DIGIT'(b_reg >> base);
    dsub        = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, borrow_reg};
    borrow_next = dsub[DIGIT];
    res_next    = (res_reg & ~(DMASK << base)) | (WIDTH'(dsub[DIGIT-1:0]) << base);
    last_digit  = (cnt_reg == CW'(N - 1));
    ovf_next    = (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]) & (res_next[WIDTH-1] ^ a_reg[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      res_reg    <= '0;
      borrow_reg <= 1'b0;
      cnt_reg    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrowOut  <= 1'b0;
      overflow   <= 1'b0;
      zero       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state_reg  <= RUN;
            a_reg      <= a;
            b_reg      <= b;
            borrow_reg <= borrowIn;
            res_reg    <= '0;
            cnt_reg    <= '0;
            busy       <= 1'b1;
          end else begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        end
        RUN: begin
          res_reg    <= res_next;
          borrow_reg <= borrow_next;
          cnt_reg    <= cnt_reg + 1'b1;
          if (last_digit) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            diff      <= res_next;
            borrowOut <= borrow_next;
            overflow  <= ovf_next;
            zero      <= (res_next == '0);
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Directed and random checks of serial_sub at DIGIT=4 (N=4), DIGIT=16 (N=1) and DIGIT=1 (N=16).
module tb_serial_sub;

  logic        clk = 1'b0;
  logic        resetN;
  logic        start, start_r;
  logic [15:0] a_in, b_in;
  logic        bin;

  logic        busy, done, borrowOut, overflow, zero;
  logic [15:0] diff;
  logic        busy_1, done_1, bo_1, ov_1, z_1;
  logic [15:0] diff_1;
  logic        busy_16, done_16, bo_16, ov_16, z_16;
  logic [15:0] diff_16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .resetN(resetN), .start(start), .a(a_in), .b(b_in), .borrowIn(bin),
    .busy(busy), .done(done), .diff(diff), .borrowOut(borrowOut),
    .overflow(overflow), .zero(zero));

  serial_sub #(.WIDTH(16), .DIGIT(16)) dut_n1 (
    .clk(clk), .resetN(resetN), .start(start_r), .a(a_in), .b(b_in), .borrowIn(bin),
    .busy(busy_1), .done(done_1), .diff(diff_1), .borrowOut(bo_1),
    .overflow(ov_1), .zero(z_1));

  serial_sub #(.WIDTH(16), .DIGIT(1)) dut_n16 (
    .clk(clk), .resetN(resetN), .start(start_r), .a(a_in), .b(b_in), .borrowIn(bin),
    .busy(busy_16), .done(done_16), .diff(diff_16), .borrowOut(bo_16),
    .overflow(ov_16), .zero(z_16));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bo;
    logic        ov;
    logic        z;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // One operation on the N=4 instance with a single-cycle start pulse
  task automatic run_op(input vec_t v, input string tag);
    logic [15:0] prev;
    int t, busy_n;
    bit seen, moved;
    prev = diff;
    a_in = v.a; b_in = v.b; bin = v.bin; start = 1'b1;
    step();
    start = 1'b0;
    t = 0; busy_n = 0; seen = 0; moved = 0;
    if (busy) busy_n++;
    while (!seen && t < 20) begin
      step();
      t++;
      if (done) seen = 1;
      else begin
        if (busy) busy_n++;
        if (diff != prev) moved = 1;
      end
    end
    check({tag, " latency"}, seen ? t : -1, 4);
    check({tag, " busy_cycles"}, busy_n, 4);
    check({tag, " diff_held_in_run"}, int'(moved), 0);
    check({tag, " diff"}, int'(diff), int'(v.d));
    check({tag, " borrowOut"}, int'(borrowOut), int'(v.bo));
    check({tag, " overflow"}, int'(overflow), int'(v.ov));
    check({tag, " zero"}, int'(zero), int'(v.z));
    step();
    check({tag, " done_single_pulse"}, int'(done), 0);
  endtask

  initial begin
    int t, last, nd, l1, l2;
    logic [15:0] ra, rb;
    logic        rbin, eov;
    logic [16:0] full;
    int s;

    vecs[0] = '{16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};

    resetN = 1'b0; start = 1'b0; start_r = 1'b0;
    a_in = 16'hFFFF; b_in = 16'h1234; bin = 1'b1;
    step(); step();
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset diff", int'(diff), 0);
    check("reset borrowOut", int'(borrowOut), 0);
    check("reset overflow", int'(overflow), 0);
    check("reset zero", int'(zero), 0);
    resetN = 1'b1;
    step();

    for (int i = 0; i < 6; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // start held high: a new operation is accepted at every DONE edge
    a_in = 16'h0005; b_in = 16'h0004; bin = 1'b1; start = 1'b1;
    step();
    t = 0; last = -1; nd = 0;
    while (nd < 3 && t < 40) begin
      step();
      t++;
      if (done) begin
        if (last < 0) check("b2b first_latency", t, 4);
        else          check("b2b period", t - last, 5);
        check("b2b diff", int'(diff), 0);
        check("b2b zero", int'(zero), 1);
        last = t;
        nd++;
      end
    end
    check("b2b done_count", nd, 3);
    step();
    start = 1'b0;
    t = 0;
    while ((busy || done) && t < 20) begin step(); t++; end
    check("b2b drained", int'(busy | done), 0);

    // start during RUN is ignored
    a_in = 16'h1234; b_in = 16'h0235; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    a_in = 16'hAAAA; b_in = 16'h1111; bin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    t = 3;
    while (!done && t < 20) begin step(); t++; end
    check("ignore latency", t, 4);
    check("ignore diff", int'(diff), 16'h0FFF);
    check("ignore borrowOut", int'(borrowOut), 0);
    step();
    check("ignore no_rerun", int'(busy), 0);

    // reset mid-RUN aborts the operation
    a_in = 16'h0000; b_in = 16'h0001; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    resetN = 1'b0;
    step();
    resetN = 1'b1;
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort diff", int'(diff), 0);
    check("abort borrowOut", int'(borrowOut), 0);
    check("abort overflow", int'(overflow), 0);
    check("abort zero", int'(zero), 0);
    nd = 0;
    repeat (8) begin step(); if (done) nd++; end
    check("abort no_done", nd, 0);
    run_op(vecs[0], "after_abort");

    // random operands on the N=1 and N=16 builds
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rbin = 1'($urandom_range(0, 1));
      full = {1'b0, ra} - {1'b0, rb} - 17'(rbin);
      s = int'($signed(ra)) - int'($signed(rb)) - int'(rbin);
      eov = (s > 32767) || (s < -32768);
      a_in = ra; b_in = rb; bin = rbin; start_r = 1'b1;
      step();
      start_r = 1'b0;
      t = 0; l1 = -1; l2 = -1;
      while ((l1 < 0 || l2 < 0) && t < 20) begin
        step();
        t++;
        if (done_1 && l1 < 0) begin
          l1 = t;
          check($sformatf("rnd%0d n1 diff", i), int'(diff_1), int'(full[15:0]));
          check($sformatf("rnd%0d n1 borrowOut", i), int'(bo_1), int'(full[16]));
          check($sformatf("rnd%0d n1 overflow", i), int'(ov_1), int'(eov));
          check($sformatf("rnd%0d n1 zero", i), int'(z_1), int'(full[15:0] == 16'h0));
        end
        if (done_16 && l2 < 0) begin
          l2 = t;
          check($sformatf("rnd%0d n16 diff", i), int'(diff_16), int'(full[15:0]));
          check($sformatf("rnd%0d n16 borrowOut", i), int'(bo_16), int'(full[16]));
          check($sformatf("rnd%0d n16 overflow", i), int'(ov_16), int'(eov));
          check($sformatf("rnd%0d n16 zero", i), int'(z_16), int'(full[15:0] == 16'h0));
        end
      end
      check($sformatf("rnd%0d n1 latency", i), l1, 1);
      check($sformatf("rnd%0d n16 latency", i), l2, 16);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
